// File: rtl/bus_chk_pkg.sv
// Shared definitions for the bus-cycle expectation checker.
//   CHK_ADDR/CHK_DATA/CHK_RW : bit positions inside the 3-bit check mask {addr,data,rw}
//   MASK_W                   : width of the check mask
//   chk_state_t              : checker FSM state encodings
package bus_chk_pkg;

    localparam int MASK_W   = 3;
    localparam int CHK_RW   = 0;
    localparam int CHK_DATA = 1;
    localparam int CHK_ADDR = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } chk_state_t;

endpackage

// File: rtl/bus_expect_table.sv
// Expectation table: DEPTH entries of {cycle, addr, data, rw, mask}.
//   clk                       : write clock
//   wr_en / wr_idx / wr_*     : single write port
//   rd_idx                    : asynchronous read index
//   rd_cycle/addr/data/rw/mask: fields of entry rd_idx
// Contents are deliberately not reset; they are only meaningful once loaded.
module bus_expect_table
    import bus_chk_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int CNT_W  = 16,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [CNT_W-1:0]  wr_cycle,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_rw,
    input  logic [MASK_W-1:0] wr_mask,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic [CNT_W-1:0]  rd_cycle,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_rw,
    output logic [MASK_W-1:0] rd_mask
);

    localparam int ENTRY_W = CNT_W + ADDR_W + DATA_W + 1 + MASK_W;

    logic [ENTRY_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= {wr_cycle, wr_addr, wr_data, wr_rw, wr_mask};
        end
    end

    assign {rd_cycle, rd_addr, rd_data, rd_rw, rd_mask} = mem[rd_idx];

endmodule

// File: rtl/bus_expect_checker.sv
// Bus-cycle checker: compares a table of expected bus cycles against the live
// CPU bus at matching sample indices and reports sticky pass/fail status.
//   clk, reset_n           : clock, asynchronous active-low reset
//   ld_en/ld_idx/ld_*      : table load port (ignored while busy)
//   n_entries              : number of valid entries, latched on start
//   start                  : arm the checker from IDLE or DONE
//   sample_en              : one pulse per CPU bus sample point
//   bus_addr/data/rw       : live CPU bus
//   busy, done, pass, fail : status (done/pass/fail sticky until start/reset)
//   fail_cnt               : failing entries, saturating at 255
//   fail_idx, fail_addr    : entry index and bus address of the first failure
//   sample_cnt             : samples counted since start
module bus_expect_checker
    import bus_chk_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int CNT_W  = 16,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              ld_en,
    input  logic [IDX_W-1:0]  ld_idx,
    input  logic [CNT_W-1:0]  ld_cycle,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              ld_rw,
    input  logic [2:0]        ld_mask,
    input  logic [IDX_W:0]    n_entries,
    input  logic              start,
    input  logic              sample_en,
    input  logic [ADDR_W-1:0] bus_addr,
    input  logic [DATA_W-1:0] bus_data,
    input  logic              bus_rw,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              fail,
    output logic [7:0]        fail_cnt,
    output logic [IDX_W-1:0]  fail_idx,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [CNT_W-1:0]  sample_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [IDX_W:0]   PTR_ONE = {{IDX_W{1'b0}}, 1'b1};

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    chk_state_t       state;
    logic [IDX_W:0]   ptr;
    logic [IDX_W:0]   n_lat;
    logic [IDX_W:0]   ptr_nxt;

    logic [CNT_W-1:0]  rd_cycle;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              rd_rw;
    logic [MASK_W-1:0] rd_mask;

    logic at_end;
    logic eval;
    logic mismatch;

    // Table is frozen while a run is in progress.
    bus_expect_table #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .CNT_W  (CNT_W)
    ) u_table (
        .clk      (clk),
        .wr_en    (ld_en && (state != ST_RUN)),
        .wr_idx   (ld_idx),
        .wr_cycle (ld_cycle),
        .wr_addr  (ld_addr),
        .wr_data  (ld_data),
        .wr_rw    (ld_rw),
        .wr_mask  (ld_mask),
        .rd_idx   (ptr[IDX_W-1:0]),
        .rd_cycle (rd_cycle),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_rw    (rd_rw),
        .rd_mask  (rd_mask)
    );

    assign at_end  = (ptr == n_lat);
    assign ptr_nxt = ptr + PTR_ONE;

    // An entry is consumed when its sample index is reached or already passed;
    // a passed index means the table is unsorted or duplicated, which fails.
    always_comb begin
        eval     = 1'b0;
        mismatch = 1'b0;
        if (state == ST_RUN && !at_end && sample_en) begin
            if (rd_cycle == sample_cnt) begin
                eval     = 1'b1;
                mismatch = (rd_mask[CHK_ADDR] && (rd_addr != bus_addr)) ||
                           (rd_mask[CHK_DATA] && (rd_data != bus_data)) ||
                           (rd_mask[CHK_RW]   && (rd_rw   != bus_rw));
            end else if (rd_cycle < sample_cnt) begin
                eval     = 1'b1;
                mismatch = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            ptr        <= '0;
            n_lat      <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            fail       <= 1'b0;
            fail_cnt   <= 8'd0;
            fail_idx   <= '0;
            fail_addr  <= '0;
            sample_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state      <= ST_RUN;
                        ptr        <= '0;
                        n_lat      <= n_entries;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        pass       <= 1'b0;
                        fail       <= 1'b0;
                        fail_cnt   <= 8'd0;
                        fail_idx   <= '0;
                        fail_addr  <= '0;
                        sample_cnt <= '0;
                    end
                end
                ST_RUN: begin
                    if (at_end) begin
                        // Only reached directly for an empty table.
                        state <= ST_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= !fail;
                    end else if (sample_en) begin
                        sample_cnt <= sample_cnt + CNT_ONE;
                        if (eval) begin
                            ptr <= ptr_nxt;
                            if (mismatch) begin
                                fail     <= 1'b1;
                                fail_cnt <= sat_inc8(fail_cnt);
                                if (!fail) begin
                                    fail_idx  <= ptr[IDX_W-1:0];
                                    fail_addr <= bus_addr;
                                end
                            end
                            // Finish together with the last compare so status
                            // lands one clock after it.
                            if (ptr_nxt == n_lat) begin
                                state <= ST_DONE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                                pass  <= !(mismatch || fail);
                            end
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_expect_checker.sv
module tb_bus_expect_checker;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        ld_en;
    logic [3:0]  ld_idx;
    logic [15:0] ld_cycle;
    logic [15:0] ld_addr;
    logic [7:0]  ld_data;
    logic        ld_rw;
    logic [2:0]  ld_mask;
    logic [4:0]  n_entries;
    logic        start;
    logic        sample_en;
    logic [15:0] bus_addr;
    logic [7:0]  bus_data;
    logic        bus_rw;
    logic        busy, done, pass, fail;
    logic [7:0]  fail_cnt;
    logic [3:0]  fail_idx;
    logic [15:0] fail_addr;
    logic [15:0] sample_cnt;

    bus_expect_checker dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .ld_en      (ld_en),
        .ld_idx     (ld_idx),
        .ld_cycle   (ld_cycle),
        .ld_addr    (ld_addr),
        .ld_data    (ld_data),
        .ld_rw      (ld_rw),
        .ld_mask    (ld_mask),
        .n_entries  (n_entries),
        .start      (start),
        .sample_en  (sample_en),
        .bus_addr   (bus_addr),
        .bus_data   (bus_data),
        .bus_rw     (bus_rw),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .fail       (fail),
        .fail_cnt   (fail_cnt),
        .fail_idx   (fail_idx),
        .fail_addr  (fail_addr),
        .sample_cnt (sample_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        pass;
        logic        fail;
        logic [7:0]  cnt;
        logic [3:0]  idx;
        logic [15:0] addr;
        logic [15:0] scnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, req);
    endtask

    task automatic push_exp(input logic p, input logic f, input logic [7:0] c,
                            input logic [3:0] i, input logic [15:0] a, input logic [15:0] s);
        exp_t e;
        e.pass = p; e.fail = f; e.cnt = c; e.idx = i; e.addr = a; e.scnt = s;
        exp_q.push_back(e);
    endtask

    // Scoreboard monitor: on each rising done, pop and compare the run result.
    initial begin : monitor
        logic done_q;
        exp_t e;
        done_q = 1'b0;
        forever begin
            @(negedge clk);
            if (done && !done_q) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("pass",       {31'd0, pass},  {31'd0, e.pass});
                    check("fail",       {31'd0, fail},  {31'd0, e.fail});
                    check("fail_cnt",   {24'd0, fail_cnt}, {24'd0, e.cnt});
                    check("fail_idx",   {28'd0, fail_idx}, {28'd0, e.idx});
                    check("fail_addr",  {16'd0, fail_addr}, {16'd0, e.addr});
                    check("sample_cnt", {16'd0, sample_cnt}, {16'd0, e.scnt});
                end
            end
            done_q = done;
        end
    end

    // Stand-in for cpu6502+rom: STX $80 (0x01) at sample 0x3f, STY $81 (0xFF) at 0x4b,
    // all other samples are reads of 0x0200+s returning s.
    task automatic drive_bus(input int s);
        if (s == 'h3f) begin
            bus_addr = 16'h0080; bus_data = 8'h01; bus_rw = 1'b0;
        end else if (s == 'h4b) begin
            bus_addr = 16'h0081; bus_data = 8'hFF; bus_rw = 1'b0;
        end else begin
            bus_addr = 16'h0200 + 16'(s); bus_data = 8'(s); bus_rw = 1'b1;
        end
    endtask

    task automatic load(input logic [3:0] idx, input logic [15:0] cyc, input logic [15:0] a,
                        input logic [7:0] d, input logic rw, input logic [2:0] m);
        ld_en = 1'b1; ld_idx = idx; ld_cycle = cyc; ld_addr = a; ld_data = d;
        ld_rw = rw; ld_mask = m;
        @(posedge clk); #1;
        ld_en = 1'b0;
    endtask

    task automatic load_good();
        load(4'd0, 16'h003f, 16'h0080, 8'h01, 1'b0, 3'b111);
        load(4'd1, 16'h004b, 16'h0081, 8'hFF, 1'b0, 3'b111);
    endtask

    task automatic run(input logic [4:0] n, input int disturb_at, input int abort_at);
        logic got_done;
        n_entries = n; start = 1'b1; sample_en = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        got_done = 1'b0;
        for (int s = 0; s < 'h60 && !got_done; s++) begin
            drive_bus(s);
            if (s == abort_at) begin
                reset_n = 1'b0;
                #1;
                check("rst_busy",       {31'd0, busy}, 32'd0);
                check("rst_done",       {31'd0, done}, 32'd0);
                check("rst_fail",       {31'd0, fail}, 32'd0);
                check("rst_sample_cnt", {16'd0, sample_cnt}, 32'd0);
                sample_en = 1'b0;
                @(posedge clk); #1;
                reset_n = 1'b1;
                @(posedge clk); #1;
                return;
            end
            if (s == disturb_at) begin
                start = 1'b1; ld_en = 1'b1; ld_idx = 4'd0; ld_cycle = 16'h003f;
                ld_addr = 16'h0080; ld_data = 8'h77; ld_rw = 1'b0; ld_mask = 3'b111;
            end
            @(posedge clk); #1;
            start = 1'b0; ld_en = 1'b0;
            if (disturb_at >= 0 && s == disturb_at + 1) begin
                check("midrun_busy",       {31'd0, busy}, 32'd1);
                check("midrun_sample_cnt", {16'd0, sample_cnt}, 32'(s + 1));
            end
            got_done = done;
        end
        sample_en = 1'b0;
        if (!got_done) check("done_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
    endtask

    initial begin
        reset_n = 1'b0; ld_en = 1'b0; ld_idx = '0; ld_cycle = '0; ld_addr = '0;
        ld_data = '0; ld_rw = 1'b0; ld_mask = '0; n_entries = '0; start = 1'b0;
        sample_en = 1'b0; bus_addr = '0; bus_data = '0; bus_rw = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy",       {31'd0, busy}, 32'd0);
        check("reset_done",       {31'd0, done}, 32'd0);
        check("reset_pass",       {31'd0, pass}, 32'd0);
        check("reset_fail",       {31'd0, fail}, 32'd0);
        check("reset_fail_cnt",   {24'd0, fail_cnt}, 32'd0);
        check("reset_fail_idx",   {28'd0, fail_idx}, 32'd0);
        check("reset_fail_addr",  {16'd0, fail_addr}, 32'd0);
        check("reset_sample_cnt", {16'd0, sample_cnt}, 32'd0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Matching program: pass
        load_good();
        push_exp(1'b1, 1'b0, 8'd0, 4'd0, 16'h0000, 16'h004c);
        run(5'd2, -1, -1);

        // Entry 0 expects wrong data
        load(4'd0, 16'h003f, 16'h0080, 8'h02, 1'b0, 3'b111);
        push_exp(1'b0, 1'b1, 8'd1, 4'd0, 16'h0080, 16'h004c);
        run(5'd2, -1, -1);

        // Same wrong data but data check masked off
        load(4'd0, 16'h003f, 16'h0080, 8'h02, 1'b0, 3'b101);
        push_exp(1'b1, 1'b0, 8'd0, 4'd0, 16'h0000, 16'h004c);
        run(5'd2, -1, -1);

        // Unsorted table: entry 1 is already behind at sample 0x4c
        load(4'd0, 16'h004b, 16'h0081, 8'hFF, 1'b0, 3'b111);
        load(4'd1, 16'h003f, 16'h0080, 8'h01, 1'b0, 3'b111);
        push_exp(1'b0, 1'b1, 8'd1, 4'd1, 16'h024c, 16'h004d);
        run(5'd2, -1, -1);

        // Empty table: done and pass one clock after entering RUN
        push_exp(1'b1, 1'b0, 8'd0, 4'd0, 16'h0000, 16'h0000);
        n_entries = 5'd0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("empty_busy", {31'd0, busy}, 32'd1);
        check("empty_done_early", {31'd0, done}, 32'd0);
        @(posedge clk); #1;
        check("empty_done", {31'd0, done}, 32'd1);
        check("empty_pass", {31'd0, pass}, 32'd1);
        @(posedge clk); #1;

        // start and ld_en mid-run are ignored
        load_good();
        push_exp(1'b1, 1'b0, 8'd0, 4'd0, 16'h0000, 16'h004c);
        run(5'd2, 'h10, -1);

        // Reset mid-run at sample 0x20, then a clean restart on the retained table
        run(5'd2, -1, 'h20);
        push_exp(1'b1, 1'b0, 8'd0, 4'd0, 16'h0000, 16'h004c);
        run(5'd2, -1, -1);

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
